// File: rtl/axil_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_master_bridge_if                                                       |
// | Core transaction handshake plus AXI4-Lite master bus for the bridge.        |
// | READ_ERR/WRITE_ERR exist only when AXIL_RESP_ERR_EN is defined.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface axil_master_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  START_READ;
   logic                  START_WRITE;
   logic [ADDR_WIDTH-1:0] TRANSACTION_RADDR;
   logic [ADDR_WIDTH-1:0] TRANSACTION_WRADDR;
   logic [DATA_WIDTH-1:0] TRANSACTION_WRDATA;
   logic [STRB_WIDTH-1:0] TRANSACTION_WSTRB;
   logic [DATA_WIDTH-1:0] TRANSACTION_RDATA;
   logic                  DONE_READ;
   logic                  DONE_WRITE;
   logic                  BUSY_READ;
   logic                  BUSY_WRITE;
`ifdef AXIL_RESP_ERR_EN
   logic                  READ_ERR;
   logic                  WRITE_ERR;
`endif

   logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
   logic [2:0]            M_AXI_AWPROT;
   logic                  M_AXI_AWVALID;
   logic                  M_AXI_AWREADY;
   logic [DATA_WIDTH-1:0] M_AXI_WDATA;
   logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
   logic                  M_AXI_WVALID;
   logic                  M_AXI_WREADY;
   logic [1:0]            M_AXI_BRESP;
   logic                  M_AXI_BVALID;
   logic                  M_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
   logic [2:0]            M_AXI_ARPROT;
   logic                  M_AXI_ARVALID;
   logic                  M_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] M_AXI_RDATA;
   logic [1:0]            M_AXI_RRESP;
   logic                  M_AXI_RVALID;
   logic                  M_AXI_RREADY;

   // Bridge view: responder to the core, master on the AXI4-Lite bus.
   modport master (
      input  START_READ, START_WRITE, TRANSACTION_RADDR, TRANSACTION_WRADDR,
             TRANSACTION_WRDATA, TRANSACTION_WSTRB,
      output TRANSACTION_RDATA, DONE_READ, DONE_WRITE, BUSY_READ, BUSY_WRITE,
`ifdef AXIL_RESP_ERR_EN
      output READ_ERR, WRITE_ERR,
`endif
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   // Environment view: the core plus the interconnect.
   modport slave (
      output START_READ, START_WRITE, TRANSACTION_RADDR, TRANSACTION_WRADDR,
             TRANSACTION_WRDATA, TRANSACTION_WSTRB,
      input  TRANSACTION_RDATA, DONE_READ, DONE_WRITE, BUSY_READ, BUSY_WRITE,
`ifdef AXIL_RESP_ERR_EN
      input  READ_ERR, WRITE_ERR,
`endif
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axil_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axil_master_bridge                                                          |
// | Turns single-beat core START/DONE requests into AXI4-Lite master accesses.  |
// | Optional: AXIL_RESP_ERR_EN adds READ_ERR/WRITE_ERR from RESP[1].            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module axil_master_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  wire logic            CLK,
   input  wire logic            RST,
   axil_master_bridge_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

   wr_state_t             wr_state_q, wr_state_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  done_write_q, done_write_d;

   rd_state_t             rd_state_q, rd_state_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  done_read_q, done_read_d;

   logic                  aw_done;
   logic                  w_done;
   logic                  unused_resp;

`ifdef AXIL_RESP_ERR_EN
   logic                  write_err_q, write_err_d;
   logic                  read_err_q, read_err_d;
`endif

   // A channel counts as done once its VALID has already dropped or handshakes now.
   assign aw_done = !awvalid_q || bus.M_AXI_AWREADY;
   assign w_done  = !wvalid_q || bus.M_AXI_WREADY;

   always_comb begin
      wr_state_d   = wr_state_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      awaddr_d     = awaddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      done_write_d = 1'b0;
`ifdef AXIL_RESP_ERR_EN
      write_err_d  = write_err_q;
`endif
      case (wr_state_q)
         W_IDLE: begin
            if (bus.START_WRITE) begin
               awaddr_d   = bus.TRANSACTION_WRADDR;
               wdata_d    = bus.TRANSACTION_WRDATA;
               wstrb_d    = bus.TRANSACTION_WSTRB;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               wr_state_d = W_ADDR_DATA;
            end
         end
         W_ADDR_DATA: begin
            if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d   = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bus.M_AXI_BVALID) begin
               bready_d     = 1'b0;
               done_write_d = 1'b1;
               wr_state_d   = W_IDLE;
`ifdef AXIL_RESP_ERR_EN
               write_err_d  = bus.M_AXI_BRESP[1];
`endif
            end
         end
         default: begin
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            wr_state_d = W_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      araddr_d    = araddr_q;
      rdata_d     = rdata_q;
      done_read_d = 1'b0;
`ifdef AXIL_RESP_ERR_EN
      read_err_d  = read_err_q;
`endif
      case (rd_state_q)
         R_IDLE: begin
            if (bus.START_READ) begin
               araddr_d   = bus.TRANSACTION_RADDR;
               arvalid_d  = 1'b1;
               rd_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (bus.M_AXI_ARREADY) begin
               arvalid_d  = 1'b0;
               rready_d   = 1'b1;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (bus.M_AXI_RVALID) begin
               rready_d    = 1'b0;
               rdata_d     = bus.M_AXI_RDATA;
               done_read_d = 1'b1;
               rd_state_d  = R_IDLE;
`ifdef AXIL_RESP_ERR_EN
               read_err_d  = bus.M_AXI_RRESP[1];
`endif
            end
         end
         default: begin
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            rd_state_d = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_state_q   <= W_IDLE;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         done_write_q <= 1'b0;
         rd_state_q   <= R_IDLE;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         araddr_q     <= '0;
         rdata_q      <= '0;
         done_read_q  <= 1'b0;
`ifdef AXIL_RESP_ERR_EN
         write_err_q  <= 1'b0;
         read_err_q   <= 1'b0;
`endif
      end else begin
         wr_state_q   <= wr_state_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         awaddr_q     <= awaddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         done_write_q <= done_write_d;
         rd_state_q   <= rd_state_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         araddr_q     <= araddr_d;
         rdata_q      <= rdata_d;
         done_read_q  <= done_read_d;
`ifdef AXIL_RESP_ERR_EN
         write_err_q  <= write_err_d;
         read_err_q   <= read_err_d;
`endif
      end
   end

   assign bus.M_AXI_AWADDR      = awaddr_q;
   assign bus.M_AXI_AWPROT      = 3'b000;
   assign bus.M_AXI_AWVALID     = awvalid_q;
   assign bus.M_AXI_WDATA       = wdata_q;
   assign bus.M_AXI_WSTRB       = wstrb_q;
   assign bus.M_AXI_WVALID      = wvalid_q;
   assign bus.M_AXI_BREADY      = bready_q;
   assign bus.M_AXI_ARADDR      = araddr_q;
   assign bus.M_AXI_ARPROT      = 3'b000;
   assign bus.M_AXI_ARVALID     = arvalid_q;
   assign bus.M_AXI_RREADY      = rready_q;
   assign bus.TRANSACTION_RDATA = rdata_q;
   assign bus.DONE_WRITE        = done_write_q;
   assign bus.DONE_READ         = done_read_q;
   // BUSY follows the state register so it falls in the same cycle DONE rises.
   assign bus.BUSY_WRITE        = (wr_state_q != W_IDLE);
   assign bus.BUSY_READ         = (rd_state_q != R_IDLE);

`ifdef AXIL_RESP_ERR_EN
   assign bus.WRITE_ERR = write_err_q;
   assign bus.READ_ERR  = read_err_q;
   assign unused_resp   = bus.M_AXI_BRESP[0] ^ bus.M_AXI_RRESP[0];
`else
   assign unused_resp   = ^{bus.M_AXI_BRESP, bus.M_AXI_RRESP};
`endif
endmodule
`default_nettype wire

// File: tb/tb_axil_master_bridge.sv
`default_nettype none
// Directed bench for axil_master_bridge: write/read latency, stalls, channel
// skew, concurrency, mid-transaction reset and (optionally) response errors.
module tb_axil_master_bridge;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   aw_hs_cnt = 0;
   int   aw_base;

   axil_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axil_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) aw_hs_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.START_READ = 0;  bus.START_WRITE = 0;
      bus.TRANSACTION_RADDR = 0; bus.TRANSACTION_WRADDR = 0;
      bus.TRANSACTION_WRDATA = 0; bus.TRANSACTION_WSTRB = 0;
      bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0;
      bus.M_AXI_BRESP = 0;   bus.M_AXI_BVALID = 0;
      bus.M_AXI_ARREADY = 0;
      bus.M_AXI_RDATA = 0;   bus.M_AXI_RRESP = 0; bus.M_AXI_RVALID = 0;

      // Reset state
      tick(); tick();
      chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
      chk("rst_wvalid",  bus.M_AXI_WVALID, 0);
      chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
      chk("rst_bready",  bus.M_AXI_BREADY, 0);
      chk("rst_rready",  bus.M_AXI_RREADY, 0);
      chk("rst_done",    {bus.DONE_READ, bus.DONE_WRITE}, 0);
      chk("rst_busy",    {bus.BUSY_READ, bus.BUSY_WRITE}, 0);
      chk("rst_rdata",   bus.TRANSACTION_RDATA, 0);
      chk("rst_awaddr",  bus.M_AXI_AWADDR, 0);
      chk("rst_prot",    {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
`ifdef AXIL_RESP_ERR_EN
      chk("rst_err",     {bus.READ_ERR, bus.WRITE_ERR}, 0);
`endif
      rst = 0;
      tick();

      // Write, slave always ready; BVALID raised before BREADY
      bus.M_AXI_AWREADY = 1; bus.M_AXI_WREADY = 1;
      bus.START_WRITE = 1; bus.TRANSACTION_WRADDR = 32'h4000_0010;
      bus.TRANSACTION_WRDATA = 32'hDEAD_BEEF; bus.TRANSACTION_WSTRB = 4'hF;
      tick();
      bus.START_WRITE = 0;
      chk("w1_awvalid", bus.M_AXI_AWVALID, 1);
      chk("w1_wvalid",  bus.M_AXI_WVALID, 1);
      chk("w1_awaddr",  bus.M_AXI_AWADDR, 32'h4000_0010);
      chk("w1_wdata",   bus.M_AXI_WDATA, 32'hDEAD_BEEF);
      chk("w1_wstrb",   bus.M_AXI_WSTRB, 4'hF);
      chk("w1_busy_n1", bus.BUSY_WRITE, 1);
      chk("w1_bready_n1", bus.M_AXI_BREADY, 0);
      bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = 2'b00;
      tick();
      chk("w1_awvalid_n2", bus.M_AXI_AWVALID, 0);
      chk("w1_wvalid_n2",  bus.M_AXI_WVALID, 0);
      chk("w1_bready_n2",  bus.M_AXI_BREADY, 1);
      chk("w1_busy_n2",    bus.BUSY_WRITE, 1);
      chk("w1_done_n2",    bus.DONE_WRITE, 0);
      tick();
      bus.M_AXI_BVALID = 0;
      chk("w1_done_n3",   bus.DONE_WRITE, 1);
      chk("w1_busy_n3",   bus.BUSY_WRITE, 0);
      chk("w1_bready_n3", bus.M_AXI_BREADY, 0);
      tick();
      chk("w1_done_n4",   bus.DONE_WRITE, 0);

      // Read with ARREADY stalled 4 cycles, RVALID 2 cycles after AR
      bus.M_AXI_ARREADY = 0;
      bus.START_READ = 1; bus.TRANSACTION_RADDR = 32'h4000_0020;
      tick();
      bus.START_READ = 0;
      chk("r2_araddr", bus.M_AXI_ARADDR, 32'h4000_0020);
      chk("r2_busy",   bus.BUSY_READ, 1);
      for (int i = 0; i < 4; i++) begin
         chk("r2_arvalid_stall", bus.M_AXI_ARVALID, 1);
         tick();
      end
      bus.M_AXI_ARREADY = 1;
      chk("r2_arvalid_hs", bus.M_AXI_ARVALID, 1);
      tick();
      bus.M_AXI_ARREADY = 0;
      chk("r2_arvalid_after", bus.M_AXI_ARVALID, 0);
      chk("r2_rready", bus.M_AXI_RREADY, 1);
      tick();
      chk("r2_rready_wait", bus.M_AXI_RREADY, 1);
      chk("r2_done_early",  bus.DONE_READ, 0);
      bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = 32'h1234_5678;
      tick();
      bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 32'h0;
      chk("r2_done",  bus.DONE_READ, 1);
      chk("r2_rdata", bus.TRANSACTION_RDATA, 32'h1234_5678);
      chk("r2_busy_done", bus.BUSY_READ, 0);
      chk("r2_rready_done", bus.M_AXI_RREADY, 0);
      tick();
      chk("r2_done_pulse", bus.DONE_READ, 0);
      chk("r2_rdata_hold", bus.TRANSACTION_RDATA, 32'h1234_5678);

      // Write skew: W handshakes 3 cycles before AW
      bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 1;
      bus.START_WRITE = 1; bus.TRANSACTION_WRADDR = 32'h4000_0100;
      bus.TRANSACTION_WRDATA = 32'hCAFE_F00D; bus.TRANSACTION_WSTRB = 4'h3;
      tick();
      bus.START_WRITE = 0;
      chk("s3_wvalid_n1", bus.M_AXI_WVALID, 1);
      tick();
      bus.M_AXI_WREADY = 0;
      chk("s3_wvalid_drop", bus.M_AXI_WVALID, 0);
      chk("s3_awvalid_held", bus.M_AXI_AWVALID, 1);
      chk("s3_bready_early", bus.M_AXI_BREADY, 0);
      tick();
      chk("s3_awvalid_held2", bus.M_AXI_AWVALID, 1);
      tick();
      bus.M_AXI_AWREADY = 1;
      chk("s3_awvalid_hs", bus.M_AXI_AWVALID, 1);
      chk("s3_awaddr", bus.M_AXI_AWADDR, 32'h4000_0100);
      tick();
      bus.M_AXI_AWREADY = 0;
      chk("s3_awvalid_drop", bus.M_AXI_AWVALID, 0);
      chk("s3_bready", bus.M_AXI_BREADY, 1);
      chk("s3_done_early", bus.DONE_WRITE, 0);
      tick();
      chk("s3_done_wait_b", bus.DONE_WRITE, 0);
      bus.M_AXI_BVALID = 1;
      tick();
      bus.M_AXI_BVALID = 0;
      chk("s3_done", bus.DONE_WRITE, 1);
      tick();

      // Concurrent read + write; repeated START_WRITE while busy is ignored
      bus.M_AXI_AWREADY = 1; bus.M_AXI_WREADY = 1; bus.M_AXI_ARREADY = 1;
      aw_base = aw_hs_cnt;
      bus.START_READ = 1; bus.TRANSACTION_RADDR = 32'h4000_0204;
      bus.START_WRITE = 1; bus.TRANSACTION_WRADDR = 32'h4000_0200;
      bus.TRANSACTION_WRDATA = 32'h1122_3344; bus.TRANSACTION_WSTRB = 4'hF;
      tick();
      bus.START_READ = 0;
      bus.TRANSACTION_WRADDR = 32'h5555_0000;
      chk("c4_awvalid", bus.M_AXI_AWVALID, 1);
      chk("c4_arvalid", bus.M_AXI_ARVALID, 1);
      tick();
      bus.START_WRITE = 0;
      chk("c4_awvalid_ign", bus.M_AXI_AWVALID, 0);
      chk("c4_bready", bus.M_AXI_BREADY, 1);
      chk("c4_rready", bus.M_AXI_RREADY, 1);
      bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = 32'hA5A5_0F0F;
      tick();
      bus.M_AXI_RVALID = 0;
      chk("c4_done_read", bus.DONE_READ, 1);
      chk("c4_rdata", bus.TRANSACTION_RDATA, 32'hA5A5_0F0F);
      chk("c4_busy_write", bus.BUSY_WRITE, 1);
      chk("c4_done_write_early", bus.DONE_WRITE, 0);
      bus.START_WRITE = 1;
      tick();
      bus.START_WRITE = 0;
      chk("c4_awvalid_ign2", bus.M_AXI_AWVALID, 0);
      chk("c4_awaddr_kept", bus.M_AXI_AWADDR, 32'h4000_0200);
      bus.M_AXI_BVALID = 1;
      tick();
      bus.M_AXI_BVALID = 0;
      chk("c4_done_write", bus.DONE_WRITE, 1);
      chk("c4_aw_count", aw_hs_cnt - aw_base, 1);
      tick();
      chk("c4_idle_aw", bus.M_AXI_AWVALID, 0);
      chk("c4_idle_busy", bus.BUSY_WRITE, 0);

      // Reset while in W_RESP and R_DATA
      bus.START_READ = 1; bus.TRANSACTION_RADDR = 32'h4000_0404;
      bus.START_WRITE = 1; bus.TRANSACTION_WRADDR = 32'h4000_0400;
      bus.TRANSACTION_WRDATA = 32'h55AA_55AA;
      tick();
      bus.START_READ = 0; bus.START_WRITE = 0;
      tick();
      chk("x5_bready_pre", bus.M_AXI_BREADY, 1);
      chk("x5_rready_pre", bus.M_AXI_RREADY, 1);
      #2 rst = 1;
      #1;
      chk("x5_bready", bus.M_AXI_BREADY, 0);
      chk("x5_rready", bus.M_AXI_RREADY, 0);
      chk("x5_busy",   {bus.BUSY_READ, bus.BUSY_WRITE}, 0);
      chk("x5_rdata",  bus.TRANSACTION_RDATA, 0);
      chk("x5_awaddr", bus.M_AXI_AWADDR, 0);
      tick();
      rst = 0;
      tick();
      chk("x5_no_done1", {bus.DONE_READ, bus.DONE_WRITE}, 0);
      tick();
      chk("x5_no_done2", {bus.DONE_READ, bus.DONE_WRITE}, 0);
      bus.START_READ = 1; bus.TRANSACTION_RADDR = 32'h4000_0300;
      tick();
      bus.START_READ = 0;
      chk("x5_arvalid", bus.M_AXI_ARVALID, 1);
      chk("x5_araddr",  bus.M_AXI_ARADDR, 32'h4000_0300);
      tick();
      chk("x5_rready_new", bus.M_AXI_RREADY, 1);
      bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = 32'h0BAD_C0DE;
      tick();
      bus.M_AXI_RVALID = 0;
      chk("x5_done_read", bus.DONE_READ, 1);
      chk("x5_rdata_new", bus.TRANSACTION_RDATA, 32'h0BAD_C0DE);
      chk("x5_no_done_write", bus.DONE_WRITE, 0);
      tick();

`ifdef AXIL_RESP_ERR_EN
      // SLVERR on write, then OKAY write clears it; SLVERR on read
      bus.START_WRITE = 1; bus.TRANSACTION_WRADDR = 32'h4000_0500;
      tick();
      bus.START_WRITE = 0;
      bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = 2'b10;
      tick(); tick();
      bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 2'b00;
      chk("e6_done_w", bus.DONE_WRITE, 1);
      chk("e6_write_err", bus.WRITE_ERR, 1);
      tick();
      chk("e6_write_err_hold", bus.WRITE_ERR, 1);
      bus.START_WRITE = 1;
      tick();
      bus.START_WRITE = 0;
      bus.M_AXI_BVALID = 1;
      tick(); tick();
      bus.M_AXI_BVALID = 0;
      chk("e6_done_w_ok", bus.DONE_WRITE, 1);
      chk("e6_write_err_clr", bus.WRITE_ERR, 0);
      bus.START_READ = 1; bus.TRANSACTION_RADDR = 32'h4000_0600;
      tick();
      bus.START_READ = 0;
      tick();
      bus.M_AXI_RVALID = 1; bus.M_AXI_RRESP = 2'b10; bus.M_AXI_RDATA = 32'hFEED_FACE;
      tick();
      bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 2'b00;
      chk("e6_done_r", bus.DONE_READ, 1);
      chk("e6_read_err", bus.READ_ERR, 1);
      chk("e6_rdata_err", bus.TRANSACTION_RDATA, 32'hFEED_FACE);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
